// File: rtl/song_rom_arbiter_if.sv
// Song ROM arbiter bus: two read requesters, the shared ROM port and status.
// master = requester/ROM side, slave = arbiter side.
interface song_rom_arbiter_if #(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 8
);
    // playback requester
    logic                 req_play;
    logic [ADDR_BITS-1:0] addr_play;
    logic                 ack_play;
    logic                 valid_play;
    logic [DATA_BITS-1:0] data_play;

    // VGA note-lookahead requester
    logic                 req_vga;
    logic [ADDR_BITS-1:0] addr_vga;
    logic                 ack_vga;
    logic                 valid_vga;
    logic [DATA_BITS-1:0] data_vga;

    // single-port song ROM
    logic [ADDR_BITS-1:0] rom_addr;
    logic [DATA_BITS-1:0] rom_data;

    // status
    logic                 vga_starved;

    modport master (
        output req_play, addr_play,
        output req_vga,  addr_vga,
        output rom_data,
        input  ack_play, valid_play, data_play,
        input  ack_vga,  valid_vga,  data_vga,
        input  rom_addr, vga_starved
    );

    modport slave (
        input  req_play, addr_play,
        input  req_vga,  addr_vga,
        input  rom_data,
        output ack_play, valid_play, data_play,
        output ack_vga,  valid_vga,  data_vga,
        output rom_addr, vga_starved
    );
endinterface

// File: rtl/song_rom_arbiter.sv
// Song ROM arbiter: shares one pipelined single-port ROM between playback
// and VGA lookahead readers, playback first with a VGA starvation override.
//
// Ports:
//   clk_in  - system clock, all logic on posedge
//   rst_in  - synchronous active-high reset
//   bus     - slave side of song_rom_arbiter_if:
//             req/addr in, ack (same-cycle accept), valid pulse and held
//             data out, per requester; rom_addr out, rom_data in;
//             vga_starved high while the VGA wait counter is saturated.
module song_rom_arbiter #(
    parameter int ADDR_BITS    = 10,
    parameter int DATA_BITS    = 8,
    parameter int ROM_LATENCY  = 2,
    parameter int VGA_MAX_WAIT = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    song_rom_arbiter_if.slave    bus
);
    localparam int WCW = $clog2(VGA_MAX_WAIT + 2);

    logic [WCW-1:0]         r_wait_cnt;
    logic [ADDR_BITS-1:0]   r_addr_hold;
    logic [ROM_LATENCY-1:0] r_tag_v;
    logic [ROM_LATENCY-1:0] r_tag_vga;
    logic                   r_valid_play;
    logic                   r_valid_vga;
    logic [DATA_BITS-1:0]   r_data_play;
    logic [DATA_BITS-1:0]   r_data_vga;

    logic                   w_starved;
    logic                   w_grant_play;
    logic                   w_grant_vga;
    logic                   w_accept;
    logic [ADDR_BITS-1:0]   w_rom_addr;
    logic                   w_ret_v;
    logic                   w_ret_vga;

    assign w_starved = (r_wait_cnt == WCW'(VGA_MAX_WAIT));

    // Playback wins ties unless VGA has waited its full budget.
    // Nothing is granted while reset is asserted.
    always_comb begin
        w_grant_vga  = 1'b0;
        w_grant_play = 1'b0;
        if (!rst_in) begin
            w_grant_vga  = bus.req_vga && (!bus.req_play || w_starved);
            w_grant_play = bus.req_play && !w_grant_vga;
        end
    end

    assign w_accept = w_grant_play | w_grant_vga;

    always_comb begin
        w_rom_addr = r_addr_hold;
        if (w_grant_vga) begin
            w_rom_addr = bus.addr_vga;
        end else if (w_grant_play) begin
            w_rom_addr = bus.addr_play;
        end
    end

    // Oldest tag lines up with rom_data for the read it belongs to.
    assign w_ret_v   = r_tag_v[ROM_LATENCY-1];
    assign w_ret_vga = r_tag_vga[ROM_LATENCY-1];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wait_cnt <= '0;
        end else if (bus.req_vga && !w_grant_vga) begin
            if (!w_starved) begin
                r_wait_cnt <= r_wait_cnt + WCW'(1);
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_addr_hold <= '0;
        end else if (w_accept) begin
            r_addr_hold <= w_rom_addr;
        end
    end

    // Owner tag shift pipeline; clearing it on reset drops in-flight reads.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_tag_v   <= '0;
            r_tag_vga <= '0;
        end else begin
            r_tag_v[0]   <= w_accept;
            r_tag_vga[0] <= w_grant_vga;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                r_tag_v[i]   <= r_tag_v[i-1];
                r_tag_vga[i] <= r_tag_vga[i-1];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_valid_play <= 1'b0;
            r_valid_vga  <= 1'b0;
            r_data_play  <= '0;
            r_data_vga   <= '0;
        end else begin
            r_valid_play <= w_ret_v && !w_ret_vga;
            r_valid_vga  <= w_ret_v && w_ret_vga;
            if (w_ret_v && !w_ret_vga) begin
                r_data_play <= bus.rom_data;
            end
            if (w_ret_v && w_ret_vga) begin
                r_data_vga <= bus.rom_data;
            end
        end
    end

    assign bus.ack_play    = w_grant_play;
    assign bus.ack_vga     = w_grant_vga;
    assign bus.rom_addr    = w_rom_addr;
    assign bus.valid_play  = r_valid_play;
    assign bus.valid_vga   = r_valid_vga;
    assign bus.data_play   = r_data_play;
    assign bus.data_vga    = r_data_vga;
    assign bus.vga_starved = w_starved;

endmodule

// File: tb/tb_song_rom_arbiter.sv
// Bench for song_rom_arbiter: directed scenarios then random traffic,
// scoreboarded against a rule-level model of arbitration and ROM reads.
module tb_song_rom_arbiter;
    localparam int L  = 2;
    localparam int MW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    song_rom_arbiter_if #(.ADDR_BITS(10), .DATA_BITS(8)) bus();

    song_rom_arbiter #(
        .ADDR_BITS(10), .DATA_BITS(8),
        .ROM_LATENCY(L), .VGA_MAX_WAIT(MW)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus(bus)
    );

    function automatic logic [7:0] rom_fn(input logic [9:0] a);
        logic [15:0] t;
        if (a == 10'd5) return 8'h3C;
        t = {6'd0, a} * 16'd40503;
        return t[15:8] ^ a[7:0];
    endfunction

    // ROM with L cycles from address to data
    logic [9:0] a_d [L] = '{default: '0};
    always @(posedge clk) begin
        for (int i = L - 1; i > 0; i--) a_d[i] <= a_d[i-1];
        a_d[0] <= bus.rom_addr;
    end
    assign bus.rom_data = rom_fn(a_d[L-1]);

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input bit ok, input string nm,
                                input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endfunction

    typedef struct {
        logic [7:0] d;
        int         due;
    } exp_t;

    exp_t qp[$];
    exp_t qv[$];
    logic [7:0] lp = 8'h00;
    logic [7:0] lv = 8'h00;
    logic [9:0] last_ra = '0;
    int mw = 0;
    int vs = 0;

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        bit   st, eap, eav;
        logic [9:0] era;

        if (bus.valid_play) begin
            if (qp.size() == 0) begin
                chk(1'b0, "valid_play_unexpected", 1, 0);
            end else begin
                e = qp.pop_front();
                chk(bus.data_play == e.d, "data_play", bus.data_play, e.d);
                chk(cyc == e.due, "latency_play", cyc, e.due);
                lp = e.d;
            end
        end else begin
            chk(bus.data_play == lp, "hold_play", bus.data_play, lp);
            if (qp.size() != 0 && qp[0].due <= cyc) begin
                chk(1'b0, "missing_valid_play", 0, 1);
                void'(qp.pop_front());
            end
        end

        if (bus.valid_vga) begin
            if (qv.size() == 0) begin
                chk(1'b0, "valid_vga_unexpected", 1, 0);
            end else begin
                e = qv.pop_front();
                chk(bus.data_vga == e.d, "data_vga", bus.data_vga, e.d);
                chk(cyc == e.due, "latency_vga", cyc, e.due);
                lv = e.d;
            end
        end else begin
            chk(bus.data_vga == lv, "hold_vga", bus.data_vga, lv);
            if (qv.size() != 0 && qv[0].due <= cyc) begin
                chk(1'b0, "missing_valid_vga", 0, 1);
                void'(qv.pop_front());
            end
        end

        st  = (mw == MW);
        eav = !rst && bus.req_vga && (!bus.req_play || st);
        eap = !rst && bus.req_play && !eav;
        era = eav ? bus.addr_vga : (eap ? bus.addr_play : last_ra);

        chk(bus.ack_play == eap, "ack_play", bus.ack_play, eap);
        chk(bus.ack_vga == eav, "ack_vga", bus.ack_vga, eav);
        chk(!(bus.ack_play && bus.ack_vga), "both_acks", 1, 0);
        chk(bus.vga_starved == st, "vga_starved", bus.vga_starved, st);
        chk(bus.rom_addr == era, "rom_addr", bus.rom_addr, era);

        if (bus.req_vga && !bus.ack_vga) vs++;
        else vs = 0;
        chk(vs <= MW, "vga_wait_bound", vs, MW);

        if (eap) qp.push_back('{d: rom_fn(bus.addr_play), due: cyc + L + 1});
        if (eav) qv.push_back('{d: rom_fn(bus.addr_vga), due: cyc + L + 1});
        if (eap || eav) last_ra = era;

        if (rst) begin
            qp.delete();
            qv.delete();
            lp = 8'h00;
            lv = 8'h00;
            last_ra = '0;
            mw = 0;
            vs = 0;
        end else if (bus.req_vga && !eav) begin
            if (mw < MW) mw++;
        end else begin
            mw = 0;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic single_read(input string tag);
        bus.req_play  = 1'b1;
        bus.addr_play = 10'd5;
        @(negedge clk);
        chk(bus.ack_play == 1'b1, {tag, "_ack"}, bus.ack_play, 1);
        chk(bus.rom_addr == 10'd5, {tag, "_rom_addr"}, bus.rom_addr, 5);
        next_cycle();
        bus.req_play = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        chk(bus.valid_play == 1'b1, {tag, "_valid"}, bus.valid_play, 1);
        chk(bus.data_play == 8'h3C, {tag, "_data"}, bus.data_play, 8'h3C);
        next_cycle();
    endtask

    initial begin
        bit gp, gv;
        bus.req_play  = 1'b0;
        bus.addr_play = '0;
        bus.req_vga   = 1'b0;
        bus.addr_vga  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(bus.valid_play == 0, "rst_valid_play", bus.valid_play, 0);
        chk(bus.valid_vga == 0, "rst_valid_vga", bus.valid_vga, 0);
        chk(bus.data_play == 0, "rst_data_play", bus.data_play, 0);
        chk(bus.data_vga == 0, "rst_data_vga", bus.data_vga, 0);
        chk(bus.rom_addr == 0, "rst_rom_addr", bus.rom_addr, 0);
        chk(bus.vga_starved == 0, "rst_starved", bus.vga_starved, 0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        single_read("single");
        repeat (2) next_cycle();

        // contention: both held high continuously
        bus.req_play  = 1'b1;
        bus.addr_play = 10'd33;
        bus.req_vga   = 1'b1;
        bus.addr_vga  = 10'd44;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk(bus.ack_vga == (i == 4), "contend_ack_vga", bus.ack_vga, i == 4);
            chk(bus.ack_play == (i != 4), "contend_ack_play", bus.ack_play, i != 4);
            chk(bus.vga_starved == (i == 4), "contend_starved",
                bus.vga_starved, i == 4);
            next_cycle();
            if (i == 4) bus.req_vga = 1'b0;
        end
        bus.req_play = 1'b0;
        repeat (4) next_cycle();

        // back-to-back playback reads
        for (int i = 0; i < 3; i++) begin
            bus.req_play  = 1'b1;
            bus.addr_play = 10'(i);
            next_cycle();
        end
        bus.req_play = 1'b0;
        repeat (4) next_cycle();

        // interleave
        bus.req_play  = 1'b1;
        bus.addr_play = 10'd10;
        next_cycle();
        bus.req_play  = 1'b0;
        bus.req_vga   = 1'b1;
        bus.addr_vga  = 10'd20;
        next_cycle();
        bus.req_vga = 1'b0;
        repeat (4) next_cycle();

        // reset while a read is in flight
        bus.req_play  = 1'b1;
        bus.addr_play = 10'd7;
        @(negedge clk);
        chk(bus.ack_play == 1'b1, "flush_ack", bus.ack_play, 1);
        next_cycle();
        bus.req_play = 1'b0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk(bus.valid_play == 0, "flush_no_valid", bus.valid_play, 0);
            chk(bus.data_play == 0, "flush_data_play", bus.data_play, 0);
            chk(bus.rom_addr == 0, "flush_rom_addr", bus.rom_addr, 0);
            next_cycle();
        end
        single_read("after_rst");
        repeat (2) next_cycle();

        // random traffic
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            gp = bus.ack_play;
            gv = bus.ack_vga;
            next_cycle();
            if (bus.req_play && !gp) begin
                if ($urandom_range(19) == 0) bus.req_play = 1'b0;
            end else begin
                bus.req_play  = ($urandom_range(9) < 6);
                bus.addr_play = 10'($urandom_range(1023));
            end
            if (bus.req_vga && !gv) begin
                if ($urandom_range(19) == 0) bus.req_vga = 1'b0;
            end else begin
                bus.req_vga  = ($urandom_range(9) < 5);
                bus.addr_vga = 10'($urandom_range(1023));
            end
            rst = ($urandom_range(999) == 0);
        end

        bus.req_play = 1'b0;
        bus.req_vga  = 1'b0;
        rst = 1'b0;
        repeat (8) next_cycle();
        @(negedge clk);
        chk(qp.size() == 0, "drain_play", qp.size(), 0);
        chk(qv.size() == 0, "drain_vga", qv.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/song_rom_arbiter.md
SONG_ROM_ARBITER -- requirements
Module: song_rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, ROM address width.
REQ-002 SHALL have parameter DATA_BITS, default 8, ROM data width.
REQ-003 SHALL have parameter ROM_LATENCY, default 2, cycles from rom_addr presented to rom_data valid.
REQ-004 SHALL have parameter VGA_MAX_WAIT, default 4, cycles a stalled VGA request waits before it overrides playback priority.
REQ-005 SHALL have port clk_in  input  1  system clock; one clock, all logic on posedge.
REQ-006 SHALL have port rst_in  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port req_play  input  1  playback read request; held with addr_play until ack_play.
REQ-008 SHALL have port addr_play  input  ADDR_BITS  playback read address.
REQ-009 SHALL have port ack_play  output  1  playback request accepted this cycle.
REQ-010 SHALL have port valid_play  output  1  one-cycle pulse, data_play updated.
REQ-011 SHALL have port data_play  output  DATA_BITS  last playback read data, held.
REQ-012 SHALL have ports req_vga, addr_vga, ack_vga, valid_vga, data_vga, identical in direction, width and meaning to the playback set, for the VGA note-lookahead requester.
REQ-013 SHALL have port rom_addr  output  ADDR_BITS  address to the single-port song ROM.
REQ-014 SHALL have port rom_data  input  DATA_BITS  song ROM read data.
REQ-015 SHALL have port vga_starved  output  1  high while the VGA wait counter is at VGA_MAX_WAIT.

Function
REQ-016 SHALL accept at most one request per cycle; ack_play and ack_vga are never high together.
REQ-017 SHALL drive rom_addr combinationally with the winner's address in the accept cycle; with no accept, rom_addr holds the last accepted address (0 after reset).
REQ-018 Arbitration: only one req high -> grant it; both high -> grant playback unless wait_cnt == VGA_MAX_WAIT, then grant VGA.
REQ-019 wait_cnt SHALL increment, saturating at VGA_MAX_WAIT, each cycle req_vga is high and ack_vga is low; SHALL clear when ack_vga is high or req_vga is low.
REQ-020 SHALL track owner tags for in-flight reads in a ROM_LATENCY-deep shift pipeline; back-to-back accepts every cycle fully pipelined.
REQ-021 For an accept in cycle N, SHALL capture rom_data into the owner's data register at the end of cycle N+ROM_LATENCY and pulse the owner's valid in cycle N+ROM_LATENCY+1; total latency ROM_LATENCY+1.
REQ-022 data_play and data_vga SHALL hold their value between valid pulses; a read never updates the other requester's data or valid.
REQ-023 Returned data SHALL arrive in accept order per requester; interleaved accepts keep correct ownership.
REQ-024 A requester SHALL be able to raise a new request the cycle after its ack; the arbiter treats req high in a post-ack cycle as a new request.
REQ-025 Responses to req_x dropped before ack SHALL NOT be generated; only accepted requests produce valid.

Reset
REQ-026 rst_in high at a clock edge SHALL clear: ack_*, valid_* = 0; data_play, data_vga = 0; rom_addr = 0; wait_cnt = 0; vga_starved = 0; tag pipeline empty.
REQ-027 Reads in flight at reset SHALL never produce a valid pulse after reset deasserts.
REQ-028 While rst_in is high, no request SHALL be acked.

Verification
REQ-029 Single read: req_play, addr_play=5, ROM[5]=0x3C, idle VGA -> ack_play in cycle 0, rom_addr=5, valid_play cycle 3, data_play=0x3C.
REQ-030 Contention: req_play and req_vga held high continuously -> playback acked cycles 0-3, wait_cnt hits 4, vga_starved high, ack_vga cycle 4, then playback resumes.
REQ-031 Back-to-back: playback addrs 0,1,2 accepted consecutive cycles -> valid_play cycles 3,4,5 with ROM[0],ROM[1],ROM[2]; data_vga unchanged.
REQ-032 Interleave: play addr 10 cycle 0, vga addr 20 cycle 1 -> valid_play cycle 3 = ROM[10], valid_vga cycle 4 = ROM[20].
REQ-033 Reset mid-flight: accept cycle 0, rst_in high cycle 1 -> no valid_play in any later cycle; all outputs 0; next request after reset returns correct data.
REQ-034 Random: both requesters random req/addr 10k cycles vs scoreboard -> every accepted read returns ROM[addr] in order to correct owner; never both acks; VGA wait never exceeds VGA_MAX_WAIT+1 cycles.
